// File: rtl/logic_fn_sched_pkg.sv
// Shared constants, FSM state type and small helpers for the logic-function scheduler.
package logic_fn_sched_pkg;

  localparam int CODE_W = 4;
  localparam int RES_W  = 3;
  localparam int CNT_W  = 5;
  localparam int NCODES = 16;

  localparam logic [CODE_W-1:0] LAST_CODE = CODE_W'(NCODES - 1);

  typedef enum logic [1:0] {
    SERVE = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } sched_state_e;

  // Cyclic successor of a requester index.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/logic_fn_sched_if.sv
// Request/response bus between requesters, the result consumer and the scheduler.
interface logic_fn_sched_if #(
  parameter int NREQ = 4
);
  import logic_fn_sched_pkg::*;

  localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]        req_valid;
  logic [CODE_W*NREQ-1:0] req_code;
  logic [NREQ-1:0]        req_ready;
  logic                   rsp_valid;
  logic [ID_W-1:0]        rsp_id;
  logic [RES_W-1:0]       rsp_result;
  logic                   rsp_ready;

  modport master (
    output req_valid, req_code, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result
  );

  modport slave (
    input  req_valid, req_code, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result
  );

endinterface

// File: rtl/logic_fn_core.sv
// Combinational 4-in/3-out logic function: code {A,B,C,D} -> result {X,Y,Z}.
module logic_fn_core
  import logic_fn_sched_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [RES_W-1:0]  result
);

  logic a_s, b_s, c_s, d_s;
  logic x_s, y_s, z_s;

  assign {a_s, b_s, c_s, d_s} = code;

  assign x_s = a_s & b_s & (c_s | d_s);
  assign y_s = (a_s ^ b_s) | (b_s & ~c_s & ~d_s) | (~a_s & c_s & d_s);
  assign z_s = (a_s & ~b_s) | (a_s & ~c_s & ~d_s) | (~b_s & (c_s ^ d_s))
             | (~a_s & b_s & c_s & d_s);

  assign result = {x_s, y_s, z_s};

endmodule

// File: rtl/logic_fn_scheduler.sv
// Round-robin sharing of one logic_fn_core among NREQ requesters, plus a
// self-test sweep that runs all 16 codes through the same core and counts ones.
module logic_fn_scheduler
  import logic_fn_sched_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  logic_fn_sched_if.slave   bus,
  input  logic              sweep_start,
  output logic              sweep_busy,
  output logic              sweep_done,
  output logic [CNT_W-1:0]  cnt_x,
  output logic [CNT_W-1:0]  cnt_y,
  output logic [CNT_W-1:0]  cnt_z
);

  localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  sched_state_e       state_r;
  sched_state_e       state_next_s;
  logic               sweep_enter_s;
  logic [ID_W-1:0]    ptr_r;
  logic [CODE_W-1:0]  sweep_code_r;

  logic               rsp_valid_r;
  logic [ID_W-1:0]    rsp_id_r;
  logic [RES_W-1:0]   rsp_result_r;
  logic               sweep_busy_r;
  logic               sweep_done_r;
  logic [CNT_W-1:0]   cnt_x_r;
  logic [CNT_W-1:0]   cnt_y_r;
  logic [CNT_W-1:0]   cnt_z_r;

  logic               slot_free_s;
  logic               arb_en_s;
  logic               grant_any_s;
  logic [NREQ-1:0]    grant_s;
  logic [ID_W-1:0]    grant_id_s;
  logic [CODE_W-1:0]  code_arr_s [NREQ];
  logic [CODE_W-1:0]  core_code_s;
  logic [RES_W-1:0]   core_res_s;

  // A grant needs a free response slot; a pending sweep_start takes priority.
  assign slot_free_s = ~rsp_valid_r | bus.rsp_ready;
  assign arb_en_s    = (state_r == SERVE) & ~sweep_start & slot_free_s;

  // Unpack the flat request code bus into one entry per requester.
  always_comb begin
    for (int k = 0; k < NREQ; k++) begin
      code_arr_s[k] = bus.req_code[k*CODE_W +: CODE_W];
    end
  end

  // Round-robin search: first valid requester at or after the pointer.
  always_comb begin
    int              sum_v;
    logic [ID_W-1:0] idx_v;
    grant_s     = '0;
    grant_id_s  = '0;
    grant_any_s = 1'b0;
    sum_v       = 0;
    idx_v       = '0;
    if (arb_en_s) begin
      for (int k = 0; k < NREQ; k++) begin
        sum_v = int'(ptr_r) + k;
        idx_v = (sum_v >= NREQ) ? ID_W'(sum_v - NREQ) : ID_W'(sum_v);
        if (!grant_any_s && bus.req_valid[idx_v]) begin
          grant_any_s    = 1'b1;
          grant_s[idx_v] = 1'b1;
          grant_id_s     = idx_v;
        end else begin
          grant_any_s = grant_any_s;
        end
      end
    end else begin
      grant_any_s = 1'b0;
    end
  end

  assign core_code_s = (state_r == SWEEP) ? sweep_code_r : code_arr_s[grant_id_s];

  logic_fn_core u_core (
    .code   (core_code_s),
    .result (core_res_s)
  );

  // Next-state logic for the serve/sweep sequencer.
  always_comb begin
    state_next_s  = state_r;
    sweep_enter_s = 1'b0;
    case (state_r)
      SERVE: begin
        if (sweep_start) begin
          state_next_s  = SWEEP;
          sweep_enter_s = 1'b1;
        end else begin
          state_next_s = SERVE;
        end
      end
      SWEEP: begin
        if (sweep_code_r == LAST_CODE) begin
          state_next_s = DONE;
        end else begin
          state_next_s = SWEEP;
        end
      end
      DONE:    state_next_s = SERVE;
      default: state_next_s = SERVE;
    endcase
  end

  // State register with busy/done flags registered alongside it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= SERVE;
      sweep_busy_r <= 1'b0;
      sweep_done_r <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      sweep_busy_r <= (state_next_s == SWEEP);
      sweep_done_r <= (state_next_s == DONE);
    end
  end

  // Sweep code counter and ones-counters; cleared only when a sweep starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sweep_code_r <= '0;
      cnt_x_r      <= '0;
      cnt_y_r      <= '0;
      cnt_z_r      <= '0;
    end else if (sweep_enter_s) begin
      sweep_code_r <= '0;
      cnt_x_r      <= '0;
      cnt_y_r      <= '0;
      cnt_z_r      <= '0;
    end else if (state_r == SWEEP) begin
      sweep_code_r <= sweep_code_r + CODE_W'(1);
      cnt_x_r      <= cnt_x_r + CNT_W'(core_res_s[2]);
      cnt_y_r      <= cnt_y_r + CNT_W'(core_res_s[1]);
      cnt_z_r      <= cnt_z_r + CNT_W'(core_res_s[0]);
    end else begin
      sweep_code_r <= sweep_code_r;
      cnt_x_r      <= cnt_x_r;
      cnt_y_r      <= cnt_y_r;
      cnt_z_r      <= cnt_z_r;
    end
  end

  // Round-robin pointer moves past the requester just granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= '0;
    end else if (grant_any_s) begin
      ptr_r <= ID_W'(wrap_inc(int'(grant_id_s), NREQ));
    end else begin
      ptr_r <= ptr_r;
    end
  end

  // Response slot: load on grant, drop on handshake, otherwise hold steady.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_r  <= 1'b0;
      rsp_id_r     <= '0;
      rsp_result_r <= '0;
    end else if (grant_any_s) begin
      rsp_valid_r  <= 1'b1;
      rsp_id_r     <= grant_id_s;
      rsp_result_r <= core_res_s;
    end else if (bus.rsp_ready) begin
      rsp_valid_r  <= 1'b0;
      rsp_id_r     <= rsp_id_r;
      rsp_result_r <= rsp_result_r;
    end else begin
      rsp_valid_r  <= rsp_valid_r;
      rsp_id_r     <= rsp_id_r;
      rsp_result_r <= rsp_result_r;
    end
  end

  assign bus.req_ready  = grant_s;
  assign bus.rsp_valid  = rsp_valid_r;
  assign bus.rsp_id     = rsp_id_r;
  assign bus.rsp_result = rsp_result_r;
  assign sweep_busy     = sweep_busy_r;
  assign sweep_done     = sweep_done_r;
  assign cnt_x          = cnt_x_r;
  assign cnt_y          = cnt_y_r;
  assign cnt_z          = cnt_z_r;

endmodule

// File: tb/tb_logic_fn_scheduler.sv
// Randomized bench for logic_fn_scheduler against a cycle-level reference model.
module tb_logic_fn_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        sweep_start = 1'b0;
  logic        sweep_busy, sweep_done;
  logic [4:0]  cnt_x, cnt_y, cnt_z;
  logic [3:0]  codes [4];

  int errors = 0;
  int checks = 0;

  // Reference model state
  int          m_ptr, m_phase;
  logic        m_rv;
  logic [1:0]  m_rid;
  logic [2:0]  m_rres;
  logic [4:0]  m_cx, m_cy, m_cz;

  logic_fn_sched_if #(.NREQ(4)) bus ();

  assign bus.req_code = {codes[3], codes[2], codes[1], codes[0]};

  logic_fn_scheduler #(.NREQ(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .sweep_start (sweep_start),
    .sweep_busy  (sweep_busy),
    .sweep_done  (sweep_done),
    .cnt_x       (cnt_x),
    .cnt_y       (cnt_y),
    .cnt_z       (cnt_z)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] ref_fn(input logic [3:0] c);
    logic a, b, cc, d;
    {a, b, cc, d} = c;
    return {a & b & (cc | d),
            (a ^ b) | (b & ~cc & ~d) | (~a & cc & d),
            (a & ~b) | (a & ~cc & ~d) | (~b & (cc ^ d)) | (~a & b & cc & d)};
  endfunction

  function automatic void model_reset();
    m_ptr = 0; m_phase = 0; m_rv = 1'b0; m_rid = 2'd0; m_rres = 3'd0;
    m_cx = 5'd0; m_cy = 5'd0; m_cz = 5'd0;
  endfunction

  function automatic logic [3:0] exp_ready();
    logic [3:0] r;
    bit found;
    int i;
    r = 4'b0000;
    found = 1'b0;
    if (m_phase == 0 && sweep_start == 1'b0 && (!m_rv || bus.rsp_ready)) begin
      for (int k = 0; k < 4; k++) begin
        i = (m_ptr + k) % 4;
        if (!found && bus.req_valid[i]) begin
          r[i] = 1'b1;
          found = 1'b1;
        end
      end
    end
    return r;
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  function automatic void model_clock();
    logic [3:0] g;
    logic [2:0] res;
    int gi;
    g = exp_ready();
    gi = -1;
    for (int k = 0; k < 4; k++) if (g[k]) gi = k;
    if (m_phase == 0) begin
      if (sweep_start) begin
        m_phase = 1; m_cx = 5'd0; m_cy = 5'd0; m_cz = 5'd0;
      end
    end else if (m_phase <= 16) begin
      res = ref_fn(4'(m_phase - 1));
      m_cx = m_cx + 5'(res[2]);
      m_cy = m_cy + 5'(res[1]);
      m_cz = m_cz + 5'(res[0]);
      m_phase = m_phase + 1;
    end else begin
      m_phase = 0;
    end
    if (gi >= 0) begin
      m_rv = 1'b1; m_rid = 2'(gi); m_rres = ref_fn(codes[gi]); m_ptr = (gi + 1) % 4;
    end else if (bus.rsp_ready) begin
      m_rv = 1'b0;
    end
  endfunction

  function automatic logic [22:0] exp_outs();
    return {m_rv, m_rv ? m_rid : 2'b00, m_rv ? m_rres : 3'b000,
            (m_phase >= 1 && m_phase <= 16), (m_phase == 17), m_cx, m_cy, m_cz};
  endfunction

  function automatic logic [22:0] act_outs();
    return {bus.rsp_valid, bus.rsp_valid ? bus.rsp_id : 2'b00,
            bus.rsp_valid ? bus.rsp_result : 3'b000,
            sweep_busy, sweep_done, cnt_x, cnt_y, cnt_z};
  endfunction

  task automatic tick();
    model_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sweep_start = 1'b0;
    bus.req_valid = 4'b0000;
    bus.rsp_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic randomize_reqs();
    bus.req_valid = 4'($urandom_range(1, 15));
    for (int k = 0; k < 4; k++) codes[k] = 4'($urandom());
  endtask

  task automatic test_reset();
    for (int k = 0; k < 4; k++) codes[k] = 4'b0000;
    bus.req_valid = 4'b0000;
    bus.rsp_ready = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if ({act_outs(), bus.req_ready} !== 27'd0) begin
      errors++; $display("FAIL reset_outs: got %h expected 0", {act_outs(), bus.req_ready});
    end
    do_reset();
    bus.req_valid = 4'b1111;
    bus.rsp_ready = 1'b1;
    #2;
    checks++;
    if (bus.req_ready !== 4'b0001 || exp_ready() !== 4'b0001) begin
      errors++; $display("FAIL reset_ptr0: got %b expected 0001", bus.req_ready);
    end
    tick();
    checks++;
    if (act_outs() !== exp_outs() || bus.rsp_id !== 2'd0) begin
      errors++; $display("FAIL reset_first_grant: got %h expected %h", act_outs(), exp_outs());
    end
  endtask

  task automatic test_single();
    codes[1] = 4'b1101;
    bus.req_valid = 4'b0010;
    bus.rsp_ready = 1'b1;
    #2;
    checks++;
    if (bus.req_ready !== 4'b0010) begin
      errors++; $display("FAIL single_ready: got %b expected 0010", bus.req_ready);
    end
    tick();
    bus.req_valid = 4'b0000;
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd1 || bus.rsp_result !== 3'b100) begin
      errors++; $display("FAIL single_rsp: got v=%b id=%0d res=%b expected v=1 id=1 res=100",
                         bus.rsp_valid, bus.rsp_id, bus.rsp_result);
    end
    #2;
    tick();
    checks++;
    if (bus.rsp_valid !== 1'b0 || act_outs() !== exp_outs()) begin
      errors++; $display("FAIL single_clear: got %h expected %h", act_outs(), exp_outs());
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] tbl [4];
    logic [3:0] one;
    tbl[0] = 3'b000; tbl[1] = 3'b011; tbl[2] = 3'b011; tbl[3] = 3'b010;
    do_reset();
    codes[0] = 4'b0000; codes[1] = 4'b0111; codes[2] = 4'b1100; codes[3] = 4'b0011;
    bus.req_valid = 4'b1111;
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      one = 4'b0001 << (c % 4);
      #2;
      checks++;
      if (bus.req_ready !== one) begin
        errors++; $display("FAIL rr_ready%0d: got %b expected %b", c, bus.req_ready, one);
      end
      tick();
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'(c % 4) || bus.rsp_result !== tbl[c % 4]) begin
        errors++; $display("FAIL rr_rsp%0d: got id=%0d res=%b expected id=%0d res=%b",
                           c, bus.rsp_id, bus.rsp_result, c % 4, tbl[c % 4]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [1:0] held_id;
    logic [2:0] held_res;
    randomize_reqs();
    bus.rsp_ready = 1'b1;
    #2;
    tick();
    held_id = m_rid;
    held_res = m_rres;
    bus.rsp_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      randomize_reqs();
      #2;
      checks++;
      if (bus.req_ready !== 4'b0000) begin
        errors++; $display("FAIL bp_ready%0d: got %b expected 0000", c, bus.req_ready);
      end
      tick();
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== held_id || bus.rsp_result !== held_res) begin
        errors++; $display("FAIL bp_hold%0d: got id=%0d res=%b expected id=%0d res=%b",
                           c, bus.rsp_id, bus.rsp_result, held_id, held_res);
      end
    end
    bus.rsp_ready = 1'b1;
    #2;
    checks++;
    if (bus.req_ready !== exp_ready() || bus.req_ready === 4'b0000) begin
      errors++; $display("FAIL bp_release: got %b expected %b", bus.req_ready, exp_ready());
    end
    tick();
    checks++;
    if (act_outs() !== exp_outs()) begin
      errors++; $display("FAIL bp_after: got %h expected %h", act_outs(), exp_outs());
    end
  endtask

  task automatic test_sweep();
    int dones, busys;
    dones = 0; busys = 0;
    randomize_reqs();
    bus.rsp_ready = 1'($urandom());
    sweep_start = 1'b1;
    #2;
    checks++;
    if (bus.req_ready !== 4'b0000) begin
      errors++; $display("FAIL sweep_start_grant: got %b expected 0000", bus.req_ready);
    end
    tick();
    sweep_start = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      if (sweep_busy) busys++;
      randomize_reqs();
      bus.rsp_ready = (c == 17) ? 1'b1 : 1'($urandom());
      #2;
      checks++;
      if (bus.req_ready !== exp_ready() || bus.req_ready !== 4'b0000) begin
        errors++; $display("FAIL sweep_ready%0d: got %b expected 0000", c, bus.req_ready);
      end
      tick();
      checks++;
      if (act_outs() !== exp_outs()) begin
        errors++; $display("FAIL sweep_outs%0d: got %h expected %h", c, act_outs(), exp_outs());
      end
      if (sweep_done) begin
        dones++;
        checks++;
        if (cnt_x !== 5'd3 || cnt_y !== 5'd10 || cnt_z !== 5'd8) begin
          errors++; $display("FAIL sweep_counts: got %0d/%0d/%0d expected 3/10/8", cnt_x, cnt_y, cnt_z);
        end
      end
    end
    checks++;
    if (dones != 1 || busys != 16) begin
      errors++; $display("FAIL sweep_len: got done=%0d busy=%0d expected done=1 busy=16", dones, busys);
    end
    randomize_reqs();
    #2;
    checks++;
    if (bus.req_ready === 4'b0000 || bus.req_ready !== exp_ready()) begin
      errors++; $display("FAIL sweep_resume: got %b expected %b", bus.req_ready, exp_ready());
    end
    tick();
  endtask

  task automatic test_reset_mid_sweep();
    int dones;
    dones = 0;
    randomize_reqs();
    bus.rsp_ready = 1'b1;
    sweep_start = 1'b1;
    #2;
    tick();
    sweep_start = 1'b0;
    for (int c = 1; c < 8; c++) begin
      #2;
      tick();
      if (sweep_done) dones++;
    end
    checks++;
    if (sweep_busy !== 1'b1) begin
      errors++; $display("FAIL mid_busy8: got %b expected 1", sweep_busy);
    end
    bus.req_valid = 4'b0000;
    rst_n = 1'b0;
    #1;
    checks++;
    if (act_outs() !== 23'd0 || bus.req_ready !== 4'b0000 || dones != 0) begin
      errors++; $display("FAIL mid_reset: got %h done=%0d expected 0 done=0", act_outs(), dones);
    end
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) begin
      #2;
      tick();
      checks++;
      if (sweep_done !== 1'b0 || act_outs() !== exp_outs()) begin
        errors++; $display("FAIL mid_after: got %h expected %h", act_outs(), exp_outs());
      end
    end
    test_sweep();
  endtask

  task automatic test_sweep_ignore();
    int dones;
    dones = 0;
    bus.rsp_ready = 1'b1;
    sweep_start = 1'b1;
    #2;
    tick();
    for (int c = 1; c <= 20; c++) begin
      randomize_reqs();
      if (c == 5 || c == 17) sweep_start = 1'b1;
      else if (c < 17) sweep_start = 1'($urandom());
      else sweep_start = 1'b0;
      #2;
      checks++;
      if (bus.req_ready !== exp_ready()) begin
        errors++; $display("FAIL ign_ready%0d: got %b expected %b", c, bus.req_ready, exp_ready());
      end
      tick();
      if (sweep_done) dones++;
      checks++;
      if (act_outs() !== exp_outs()) begin
        errors++; $display("FAIL ign_outs%0d: got %h expected %h", c, act_outs(), exp_outs());
      end
    end
    checks++;
    if (dones != 1) begin
      errors++; $display("FAIL ign_done_count: got %0d expected 1", dones);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      bus.req_valid = 4'($urandom_range(0, 15));
      for (int k = 0; k < 4; k++) codes[k] = 4'($urandom());
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      sweep_start = ($urandom_range(0, 39) == 0);
      #2;
      checks++;
      if (bus.req_ready !== exp_ready()) begin
        errors++; $display("FAIL rnd_ready%0d: got %b expected %b", c, bus.req_ready, exp_ready());
      end
      tick();
      checks++;
      if (act_outs() !== exp_outs()) begin
        errors++; $display("FAIL rnd_outs%0d: got %h expected %h", c, act_outs(), exp_outs());
      end
    end
    sweep_start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_sweep();
    test_reset_mid_sweep();
    test_sweep_ignore();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
